skeleton_pass_controller: RTL and testbench

Parametrised successor to the single-pass image/mask controller. It owns the N×N image memory and loads it from a streaming input. It runs repeated two-sub-pass thinning scans, handing each pixel to an external neighbourhood evaluator and applying deletions only at the end of each sub-pass. It stops on convergence or when the pass limit is reached, then streams the skeleton out. It sits between the pixel loader and the readout path, replacing the free-running counter and write-mux arrangement.

---
 rtl/skeleton_pass_controller.sv | 197 +++++++++++++++++++
 tb/tb_skeleton_pass_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skeleton_pass_controller.sv
// Image memory owner and sequencer for repeated two-sub-pass thinning scans:
// loads an N*N image, defers evaluator deletions to a commit sweep, then streams the skeleton out.
module skeleton_pass_controller #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int MAX_PASSES = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [pixelWidth-1:0]           in_data,
    output logic                            scan_valid,
    output logic [bitSize:0]                scan_addr,
    output logic                            sub_pass,
    input  logic                            eval_valid,
    input  logic                            eval_delete,
    input  logic [bitSize:0]                nb_addr,
    output logic [pixelWidth-1:0]           nb_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [pixelWidth-1:0]           out_data,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_PASSES+1)-1:0] pass_count,
    output logic                            converged
);
    localparam int NPIX = N * N;
    localparam int AW   = bitSize + 1;
    localparam int CW   = AW + 1;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int DW   = $clog2(NPIX + 1);
    localparam int PW   = $clog2(MAX_PASSES + 1);

    localparam logic [CW-1:0] LAST_ADDR = CW'(NPIX - 1);
    localparam logic [CW-1:0] END_ADDR  = CW'(NPIX);
    localparam logic [PW-1:0] PASS_MAX  = PW'(MAX_PASSES);
    localparam logic [DW-1:0] DEL_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_WAIT,
        S_COMMIT,
        S_CHECK,
        S_READOUT
    } state_t;

    state_t state, state_next;

    logic [pixelWidth-1:0] mem [NPIX];
    logic [NPIX-1:0]       del_map;
    logic [CW-1:0]         addr;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         del_total;
    logic                  ro_armed;
    logic                  mem_we;
    logic [pixelWidth-1:0] mem_wdata;
    logic [PW-1:0]         pass_next;
    logic                  addr_last;
    logic                  stop_run;
    logic                  last_beat;

    assign idx       = addr[IW-1:0];
    assign addr_last = (addr == LAST_ADDR);
    assign pass_next = (pass_count == PASS_MAX) ? pass_count : pass_count + 1'b1;
    assign stop_run  = (del_total == '0) || (pass_next == PASS_MAX);
    assign last_beat = ro_armed && out_valid && out_ready && (addr == END_ADDR);
    assign busy      = (state != S_IDLE);
    assign scan_addr = addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        scan_valid = 1'b0;
        case (state)
            S_IDLE:    if (start) state_next = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && addr_last) state_next = S_SCAN;
            end
            S_SCAN: begin
                scan_valid = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT:    if (eval_valid) state_next = addr_last ? S_COMMIT : S_SCAN;
            S_COMMIT:  if (addr_last) state_next = S_CHECK;
            S_CHECK:   state_next = (sub_pass && stop_run) ? S_READOUT : S_SCAN;
            S_READOUT: if (last_beat) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Single write port shared by the loader and the commit sweep.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = in_data;
        if (state == S_LOAD && in_valid) begin
            mem_we = 1'b1;
        end else if (state == S_COMMIT && del_map[idx]) begin
            mem_we    = 1'b1;
            mem_wdata = '0;
        end
    end

    // Evaluator reads see the pre-commit image because writes only land during LOAD and COMMIT.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= mem_wdata;
        nb_data <= ({1'b0, nb_addr} < END_ADDR) ? mem[nb_addr[IW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            del_map    <= '0;
            del_total  <= '0;
            pass_count <= '0;
            converged  <= 1'b0;
            sub_pass   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done       <= 1'b0;
            ro_armed   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr       <= '0;
                        del_map    <= '0;
                        del_total  <= '0;
                        pass_count <= '0;
                        converged  <= 1'b0;
                        sub_pass   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) addr <= addr_last ? '0 : addr + 1'b1;
                end
                S_WAIT: begin
                    if (eval_valid) begin
                        if (eval_delete) begin
                            del_map[idx] <= 1'b1;
                            if (del_total != DEL_MAX) del_total <= del_total + 1'b1;
                        end
                        addr <= addr_last ? '0 : addr + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (del_map[idx]) del_map[idx] <= 1'b0;
                    addr <= addr_last ? '0 : addr + 1'b1;
                end
                S_CHECK: begin
                    if (!sub_pass) begin
                        sub_pass <= 1'b1;
                    end else begin
                        pass_count <= pass_next;
                        if (stop_run) begin
                            converged <= (del_total == '0);
                        end else begin
                            del_total <= '0;
                            sub_pass  <= 1'b0;
                        end
                    end
                end
                S_READOUT: begin
                    // The first cycle only arms the stream so the first beat lands two cycles in.
                    if (!ro_armed) begin
                        ro_armed <= 1'b1;
                    end else if (last_beat) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        addr      <= '0;
                        ro_armed  <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        if (addr != END_ADDR) begin
                            out_data  <= mem[idx];
                            out_valid <= 1'b1;
                            addr      <= addr + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_skeleton_pass_controller.sv
// Self-checking bench for skeleton_pass_controller: table-driven runs against a
// pass/sub-pass reference model, plus a reset-during-commit sequence.
module tb_skeleton_pass_controller;
    localparam int N    = 8;
    localparam int BS   = 6;
    localparam int PXW  = 8;
    localparam int MAXP = 3;
    localparam int NPIX = N * N;
    localparam int PW   = $clog2(MAXP + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [PXW-1:0] in_data = '0;
    logic           scan_valid;
    logic [BS:0]    scan_addr;
    logic           sub_pass;
    logic           eval_valid = 1'b0;
    logic           eval_delete = 1'b0;
    logic [BS:0]    nb_addr = '0;
    logic [PXW-1:0] nb_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [PXW-1:0] out_data;
    logic           busy;
    logic           done;
    logic [PW-1:0]  pass_count;
    logic           converged;

    skeleton_pass_controller #(
        .N(N), .bitSize(BS), .pixelWidth(PXW), .MAX_PASSES(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .scan_valid(scan_valid), .scan_addr(scan_addr), .sub_pass(sub_pass),
        .eval_valid(eval_valid), .eval_delete(eval_delete),
        .nb_addr(nb_addr), .nb_data(nb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .pass_count(pass_count), .converged(converged)
    );

    always #5 clk = ~clk;

    // One run: image kind, evaluator policy, latency, spurious strobes, ready pattern, expected stop.
    typedef struct {
        int image_kind;
        int policy;
        int lat_max;
        int spurious;
        int ready_mode;
        int exp_pc;
        int exp_conv;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_pass   = 0;

    logic [PXW-1:0] init_img [NPIX];
    logic [PXW-1:0] exp_img  [NPIX];
    logic [PXW-1:0] snap     [MAXP][2][NPIX];
    bit             dec      [MAXP][2][NPIX];
    int             model_pc;
    int             model_conv;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic make_image(input int kind);
        for (int a = 0; a < NPIX; a++) begin
            case (kind)
                0:       init_img[a] = '0;
                1:       init_img[a] = ((a % N) >= 2 && (a % N) <= 4) ? (8'h80 | 8'(a)) : 8'h00;
                default: init_img[a] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            endcase
        end
    endtask

    // Whole-image model: each sub-pass judges a frozen snapshot, deletions apply at its end.
    task automatic run_model(input int policy);
        logic [PXW-1:0] img [NPIX];
        int total;
        bit taken;
        for (int a = 0; a < NPIX; a++) img[a] = init_img[a];
        for (int p = 0; p < MAXP; p++)
            for (int sp = 0; sp < 2; sp++)
                for (int a = 0; a < NPIX; a++) begin
                    dec[p][sp][a]  = 1'b0;
                    snap[p][sp][a] = '0;
                end
        model_pc   = MAXP;
        model_conv = 0;
        for (int p = 0; p < MAXP; p++) begin
            total = 0;
            for (int sp = 0; sp < 2; sp++) begin
                taken = 1'b0;
                for (int a = 0; a < NPIX; a++) begin
                    bit d;
                    snap[p][sp][a] = img[a];
                    case (policy)
                        0: d = 1'b0;
                        1: d = (p == 0 && sp == 0 && a == 10);
                        2: begin
                            d = (img[a] != 0) && !taken;
                            if (d) taken = 1'b1;
                        end
                        default: d = (img[a] != 0) && ($urandom_range(0, 3) == 0);
                    endcase
                    dec[p][sp][a] = d;
                    total += int'(d);
                end
                for (int a = 0; a < NPIX; a++) if (dec[p][sp][a]) img[a] = '0;
            end
            if (total == 0) begin
                model_pc   = p + 1;
                model_conv = 1;
                break;
            end
        end
        for (int a = 0; a < NPIX; a++) exp_img[a] = img[a];
    endtask

    task automatic reset_dut();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        eval_valid = 1'b0; eval_delete = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check_output("rst_in_ready",   32'(in_ready),   32'd0);
        check_output("rst_scan_valid", 32'(scan_valid), 32'd0);
        check_output("rst_out_valid",  32'(out_valid),  32'd0);
        check_output("rst_busy",       32'(busy),       32'd0);
        check_output("rst_done",       32'(done),       32'd0);
        check_output("rst_converged",  32'(converged),  32'd0);
        check_output("rst_sub_pass",   32'(sub_pass),   32'd0);
        check_output("rst_pass_count", 32'(pass_count), 32'd0);
        check_output("rst_scan_addr",  32'(scan_addr),  32'd0);
        check_output("rst_out_data",   32'(out_data),   32'd0);
        rst = 1'b0;
    endtask

    task automatic load_image();
        int i = 0;
        int cyc = 0;
        check_output("idle_in_ready", 32'(in_ready), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("load_in_ready", 32'(in_ready), 32'd1);
        check_output("load_busy",     32'(busy),     32'd1);
        while (i < NPIX && cyc < 1000) begin
            in_valid = ($urandom % 4 != 0);
            in_data  = init_img[i];
            @(posedge clk); #1;
            cyc++;
            if (in_valid) i++;
        end
        in_valid = 1'b0;
        check_output("load_beats", 32'(i), 32'(NPIX));
    endtask

    // Plays the evaluator for nreq requests using the model's decision table.
    task automatic evaluate(input int nreq, input int lat_max, input int spurious);
        int p, sp, a, lat, cyc, na;
        bit nb_chk;
        for (int r = 0; r < nreq; r++) begin
            p  = r / (2 * NPIX);
            sp = (r / NPIX) % 2;
            a  = r % NPIX;
            cyc = 0;
            while (!scan_valid && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!scan_valid) begin
                check_output("scan_timeout", 32'(r), 32'(nreq));
                return;
            end
            check_output("scan_addr", 32'(scan_addr), 32'(a));
            check_output("sub_pass",  32'(sub_pass),  32'(sp));
            lat    = int'($urandom_range(1, lat_max));
            nb_chk = (r % 4 == 0);
            if (nb_chk && lat < 2) lat = 2;
            if (spurious != 0 && $urandom_range(0, 2) == 0) begin
                eval_valid  = 1'b1;
                eval_delete = ~dec[p][sp][a];
            end
            @(posedge clk); #1;
            eval_valid  = 1'b0;
            eval_delete = 1'b0;
            if (nb_chk) begin
                na = ((r / 4) % 2 == 1) ? 10 : int'($urandom_range(0, NPIX - 1));
                nb_addr = 7'(na);
                @(posedge clk); #1;
                check_output("nb_data", 32'(nb_data), 32'(snap[p][sp][na]));
                lat = lat - 1;
            end
            repeat (lat - 1) begin
                @(posedge clk); #1;
            end
            eval_valid  = 1'b1;
            eval_delete = dec[p][sp][a];
            @(posedge clk); #1;
            eval_valid  = 1'b0;
            eval_delete = 1'b0;
        end
    endtask

    task automatic do_readout(input int mode, input int epc, input int econ);
        int  cyc = 0;
        int  extra = 0;
        int  beats = 0;
        int  dones = 0;
        bit  rdy;
        bit  prev_stall = 1'b0;
        logic            v;
        logic [PXW-1:0]  d;
        logic [PXW-1:0]  prev_data = '0;
        while (!out_valid && cyc < 400) begin
            if (scan_valid) extra++;
            @(posedge clk); #1;
            cyc++;
        end
        check_output("extra_requests", 32'(extra),      32'd0);
        check_output("readout_start",  32'(out_valid),  32'd1);
        check_output("pass_count",     32'(pass_count), 32'(epc));
        check_output("converged",      32'(converged),  32'(econ));
        cyc = 0;
        while (beats < NPIX && cyc < 1000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            out_ready = rdy;
            if (prev_stall) begin
                check_output("hold_valid", 32'(out_valid), 32'd1);
                check_output("hold_data",  32'(out_data),  32'(prev_data));
            end
            v = out_valid;
            d = out_data;
            @(posedge clk); #1;
            cyc++;
            if (done) dones++;
            if (v && rdy) begin
                check_output("out_data", 32'(d), 32'(exp_img[beats]));
                beats++;
            end
            prev_stall = v && !rdy;
            prev_data  = d;
        end
        out_ready = 1'b0;
        check_output("readout_beats", 32'(beats), 32'(NPIX));
        check_output("done_pulses",   32'(dones), 32'd1);
        @(posedge clk); #1;
        check_output("done_after", 32'(done), 32'd0);
        check_output("idle_busy",  32'(busy), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int epc, econ;
        reset_dut();
        make_image(v.image_kind);
        run_model(v.policy);
        epc  = (v.exp_pc   >= 0) ? v.exp_pc   : model_pc;
        econ = (v.exp_conv >= 0) ? v.exp_conv : model_conv;
        load_image();
        evaluate(2 * NPIX * epc, v.lat_max, v.spurious);
        do_readout(v.ready_mode, epc, econ);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 1, 0, 0, 1, 1};
        vecs[1] = '{1, 1, 3, 0, 1, 2, 1};
        vecs[2] = '{1, 2, 4, 0, 2, 3, 0};
        vecs[3] = '{2, 3, 7, 1, 2, -1, -1};
        vecs[4] = '{2, 0, 7, 1, 1, 1, 1};

        for (int i = 0; i < 5; i++) begin
            $display("[TB] run %0d", i);
            apply_stimulus(vecs[i]);
        end

        $display("[TB] reset during commit");
        reset_dut();
        make_image(1);
        run_model(2);
        load_image();
        evaluate(NPIX, 1, 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_output("commit_busy", 32'(busy), 32'd1);
        reset_dut();
        apply_stimulus(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
